// File: rtl/note_sequencer_pkg.sv
// Shared sound definitions used by the note sequencer and the piezo tone generator.
// Contents:
//   - melody ids
//   - note-id and note-index widths
//   - sequencer FSM state type
//   - helper that tells whether a request id is playable
package note_sequencer_pkg;

  localparam int unsigned NOTE_ID_W        = 4;
  localparam int unsigned NOTE_IDX_W       = 3;
  localparam int unsigned NOTES_PER_MELODY = 4;

  typedef logic [NOTE_ID_W-1:0]  note_id_t;
  typedef logic [NOTE_IDX_W-1:0] note_idx_t;

  localparam note_id_t NOTE_IDLE  = 4'd0;
  localparam note_id_t NOTE_100W  = 4'd1;
  localparam note_id_t NOTE_500W  = 4'd2;
  localparam note_id_t NOTE_1000W = 4'd3;
  localparam note_id_t NOTE_PROD1 = 4'd4;
  localparam note_id_t NOTE_BUY1  = 4'd8;
  localparam note_id_t NOTE_WARN  = 4'd12;

  typedef enum logic {StIdle, StPlay} seq_state_e;

  // Ids 0 and 13..15 name no melody and are ignored.
  function automatic logic is_valid_id(note_id_t id);
    return (id >= NOTE_100W) && (id <= NOTE_WARN);
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Sound request / note stream bundle between the control FSM and the note sequencer.
// master: control side, drives req/req_note and observes the note stream.
// slave:  sequencer side.
//   req          one-cycle sound request strobe
//   req_note     melody id for req
//   note_state   melody id being played, 0 = silent
//   note_played  note index 1..4, 0 = silent
//   busy         melody playing
//   done         one-cycle pulse when a melody completes
interface note_sequencer_if;
  import note_sequencer_pkg::*;

  logic      req;
  note_id_t  req_note;
  note_id_t  note_state;
  note_idx_t note_played;
  logic      busy;
  logic      done;

  modport master (
    output req, req_note,
    input  note_state, note_played, busy, done
  );

  modport slave (
    input  req, req_note,
    output note_state, note_played, busy, done
  );

endinterface

// File: rtl/note_sequencer_timer.sv
// Per-note duration counter.
//   clk, rst  clock, asynchronous active-high reset
//   clear     synchronous restart of the count at 0
//   en        count while a melody plays
//   last      high on the final cycle of a note (count == NOTE_LEN-1)
// The counter wraps to 0 on its own after the last cycle.
module note_sequencer_timer #(
  parameter int unsigned NOTE_LEN = 250000,
  parameter int unsigned CNT_W    = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam logic [CNT_W-1:0] LastVal = CNT_W'(NOTE_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last = en && (cnt_q == LastVal);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || last) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: turns one-cycle sound requests into the note_state / note_played stream
// for the piezo tone generator. Each melody is 4 notes of NOTE_LEN cycles. One follow-up
// request is queued (latest wins); the warning melody preempts anything.
//   clk, rst  clock, asynchronous active-high reset
//   bus       note_sequencer_if.slave (req/req_note in; note_state/note_played/busy/done out)
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned NOTE_LEN = 250000,
  parameter int unsigned CNT_W    = 18
) (
  input  logic             clk,
  input  logic             rst,
  note_sequencer_if.slave  bus
);

  seq_state_e state_q, state_d;
  note_id_t   id_q, id_d;
  note_idx_t  idx_q, idx_d;
  note_id_t   pend_id_q, pend_id_d;
  logic       pend_v_q, pend_v_d;
  logic       done_q, done_d;

  logic clear, last, req_ok, req_warn, mel_end;

  assign req_ok   = bus.req && is_valid_id(bus.req_note);
  assign req_warn = req_ok && (bus.req_note == NOTE_WARN);
  assign mel_end  = last && (idx_q == note_idx_t'(NOTES_PER_MELODY));

  note_sequencer_timer #(
    .NOTE_LEN (NOTE_LEN),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (state_q == StPlay),
    .last  (last)
  );

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    idx_d     = idx_q;
    pend_id_d = pend_id_q;
    pend_v_d  = pend_v_q;
    done_d    = 1'b0;
    clear     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_ok) begin
          state_d = StPlay;
          id_d    = bus.req_note;
          idx_d   = note_idx_t'(1);
          clear   = 1'b1;
        end
      end
      StPlay: begin
        // A melody finishing in the same cycle as a warn request still counts as completed.
        done_d = mel_end;
        if (req_warn) begin
          id_d     = NOTE_WARN;
          idx_d    = note_idx_t'(1);
          clear    = 1'b1;
          pend_v_d = 1'b0;
        end else if (mel_end) begin
          pend_v_d = 1'b0;
          if (req_ok) begin
            // A request arriving with the end replaces any pending one.
            id_d  = bus.req_note;
            idx_d = note_idx_t'(1);
          end else if (pend_v_q) begin
            id_d  = pend_id_q;
            idx_d = note_idx_t'(1);
          end else begin
            state_d = StIdle;
            id_d    = NOTE_IDLE;
            idx_d   = '0;
          end
        end else begin
          if (last) begin
            idx_d = idx_q + 1'b1;
          end
          if (req_ok) begin
            pend_v_d  = 1'b1;
            pend_id_d = bus.req_note;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      id_q      <= NOTE_IDLE;
      idx_q     <= '0;
      pend_id_q <= NOTE_IDLE;
      pend_v_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      pend_id_q <= pend_id_d;
      pend_v_q  <= pend_v_d;
      done_q    <= done_d;
    end
  end

  assign bus.note_state  = id_q;
  assign bus.note_played = idx_q;
  assign bus.busy        = (idx_q != '0);
  assign bus.done        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with NOTE_LEN=4. A timeline model (current melody, cycles elapsed
// in it, pending slot) predicts each cycle's outputs into a queue; a negedge monitor pops and
// compares. Directed scenarios are followed by random requests.
module tb_note_sequencer;

  localparam int N = 4;
  localparam int MEL_LEN = 4 * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  note_sequencer_if bus ();

  note_sequencer #(
    .NOTE_LEN (N),
    .CNT_W    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] pl;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: melody id (0 = silent), cycles elapsed since it started, pending slot.
  int m_id, m_el, m_pid;
  bit m_pv;

  function automatic obs_t actual();
    obs_t o;
    o.st   = bus.note_state;
    o.pl   = bus.note_played;
    o.busy = bus.busy;
    o.done = bus.done;
    return o;
  endfunction

  function automatic void model_reset();
    m_id = 0;
    m_el = 0;
    m_pv = 0;
    m_pid = 0;
  endfunction

  task automatic model_step(input bit r, input int id);
    obs_t o;
    bit valid, finishing, d;
    valid = r && (id >= 1) && (id <= 12);
    d = 0;
    if (m_id != 0) begin
      finishing = (m_el == MEL_LEN - 1);
      d = finishing;
      if (valid && id == 12) begin
        m_id = 12; m_el = 0; m_pv = 0;
      end else if (finishing) begin
        if (valid) begin
          m_id = id; m_el = 0;
        end else if (m_pv) begin
          m_id = m_pid; m_el = 0;
        end else begin
          m_id = 0; m_el = 0;
        end
        m_pv = 0;
      end else begin
        m_el++;
        if (valid) begin
          m_pv = 1; m_pid = id;
        end
      end
    end else if (valid) begin
      m_id = id; m_el = 0;
    end
    o.st   = 4'(m_id);
    o.pl   = (m_id != 0) ? 3'((m_el / N) + 1) : 3'd0;
    o.busy = (m_id != 0);
    o.done = d;
    exp_q.push_back(o);
  endtask

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s t=%0t: got st=%0d pl=%0d busy=%0b done=%0b, want st=%0d pl=%0d busy=%0b done=%0b",
               name, $time, got.st, got.pl, got.busy, got.done,
               want.st, want.pl, want.busy, want.done);
    end
  endtask

  // Called at posedge+1; drives inputs for the next edge and predicts its result.
  task automatic cycle(input bit r, input int id);
    bus.req      = r;
    bus.req_note = 4'(id);
    @(posedge clk);
    model_step(r, id);
    #1;
    bus.req      = 1'b0;
    bus.req_note = 4'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_async", actual(), '0);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: one prediction per clock, compared mid-cycle.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", actual(), e);
      end
    end
  end

  initial begin
    obs_t w;
    bus.req      = 1'b0;
    bus.req_note = 4'd0;
    rst          = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_state", actual(), '0);

    // 1: single melody, first-note latency of one cycle.
    cycle(1, 1);
    w = '{st: 4'd1, pl: 3'd1, busy: 1'b1, done: 1'b0};
    check("start_latency", actual(), w);
    idle(MEL_LEN + 3);

    // 2: invalid ids ignored.
    cycle(1, 0);
    cycle(1, 13);
    cycle(1, 15);
    check("invalid_ignored", actual(), '0);
    idle(3);

    // 3: latest pending request wins and starts with done.
    cycle(1, 4);
    idle(4);
    cycle(1, 8);
    cycle(0, 0);
    cycle(1, 9);
    idle(2 * MEL_LEN + 4);

    // 4: warn preempts and clears pending.
    cycle(1, 2);
    idle(2);
    cycle(1, 5);
    idle(5);
    cycle(1, 12);
    w = '{st: 4'd12, pl: 3'd1, busy: 1'b1, done: 1'b0};
    check("warn_preempt", actual(), w);
    idle(MEL_LEN + 4);

    // 5: request on the last cycle of note 4 with empty slot.
    cycle(1, 1);
    idle(MEL_LEN - 1);
    cycle(1, 3);
    w = '{st: 4'd3, pl: 3'd1, busy: 1'b1, done: 1'b1};
    check("back_to_back", actual(), w);
    idle(MEL_LEN + 3);

    // 6: reset mid note 3 with pending full.
    cycle(1, 6);
    cycle(1, 7);
    idle(8);
    @(negedge clk);
    #1;
    do_reset();
    idle(6);
    check("idle_after_reset", actual(), '0);

    // Random requests, warn and invalid ids included.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) cycle(1, int'($urandom_range(0, 15)));
      else cycle(0, 0);
    end
    idle(2 * MEL_LEN + 4);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d predictions left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
